v_multi_vc_sender: RTL and testbench
====================================

V_MULTI_VC_SENDER -- requirements
Module: v_multi_vc_sender

Interface
REQ-001 Parameter FLIT_W, default 256, meaning flit payload width in bits.
REQ-002 Parameter BUF_DEPTH, default 8, meaning injection buffer entries (power of two, >=2).
REQ-003 Parameter VC_NUM, default 4, meaning output VC count (>=1); VC_IDX_W = max(1, clog2(VC_NUM)).
REQ-004 Parameter VC_DEPTH, default 2, meaning credits per VC at reset; CRD_W = clog2(VC_DEPTH+1).
REQ-005 Parameter GAP_W, default 8, meaning width of the injection-gap control.
REQ-006 Parameter TIMEOUT_THRESHOLD, default 64, meaning stall cycles before timeout is flagged.
REQ-007 clk  input  1  sole clock, all state on rising edge.
REQ-008 rst  input  1  synchronous reset, active-high.
REQ-009 new_test_vld_i / new_test_rdy_o  input/output  1/1  enqueue handshake from test generator.
REQ-010 new_flit_i  input  FLIT_W  flit to send; new_qos_hi_i  input  1  high-priority flag.
REQ-011 tx_flit_v_o  output  1  flit valid to DUT inport (single-cycle, no backpressure).
REQ-012 tx_flit_o  output  FLIT_W  flit payload; tx_flit_vc_id_o  output  VC_IDX_W  VC used.
REQ-013 tx_lcrd_v_i / tx_lcrd_id_i  input  1 / VC_IDX_W  credit return from DUT.
REQ-014 sb_vld_o / sb_rdy_i  output/input  1/1  scoreboard record handshake; sb_vc_id_o output VC_IDX_W; sb_sent_cycle_o output 64.
REQ-015 mcycle_i  input  64  system cycle count; min_gap_i  input  GAP_W  minimum idle cycles between sends.
REQ-016 timeout_o  output  1  sticky stall-timeout flag; crd_err_o  output  1  sticky credit-overflow flag.

Function
REQ-017 Injection buffer SHALL be a FIFO of BUF_DEPTH {flit, qos_hi} entries; new_test_rdy_o = not full; enqueue when vld&rdy; simultaneous enqueue and dequeue when full SHALL NOT be accepted (rdy low when full).
REQ-018 Each VC SHALL keep a credit counter reset to VC_DEPTH.
REQ-019 Send SHALL decrement the sent VC counter by 1; credit return SHALL increment tx_lcrd_id_i counter by 1; both on same VC same cycle SHALL leave it unchanged.
REQ-020 A return that would exceed VC_DEPTH SHALL saturate the counter at VC_DEPTH and set crd_err_o.
REQ-021 VC selection: qos_hi head SHALL use only VC VC_NUM-1; normal head SHALL round-robin among VC 0..VC_NUM-2 with credit>0, starting after the last normal VC granted (VC_NUM=1: all heads use VC 0).
REQ-022 Gap counter SHALL reset to all-ones (saturated), clear to 0 on send, increment saturating otherwise; send requires gap counter >= min_gap_i.
REQ-023 tx_flit_v_o SHALL be combinational: FIFO non-empty AND selected VC credit>0 AND sb_rdy_i AND gap satisfied; same cycle the FIFO head dequeues.
REQ-024 tx_flit_o = head flit; tx_flit_vc_id_o = selected VC; sb_vld_o = tx_flit_v_o; sb_vc_id_o = tx_flit_vc_id_o; sb_sent_cycle_o = mcycle_i.
REQ-025 Latency: flit enqueued in cycle N SHALL be sendable no earlier than cycle N+1.
REQ-026 Stall counter SHALL clear on send or FIFO empty, else increment saturating; reaching TIMEOUT_THRESHOLD SHALL set timeout_o.
REQ-027 A credit returned in cycle N SHALL be usable in cycle N+1, not N.

Reset
REQ-028 On rst high at a clock edge: FIFO empty, credits = VC_DEPTH, RR pointer = VC 0 next, gap counter saturated, stall counter 0, timeout_o=0, crd_err_o=0.
REQ-029 Outputs during/after reset: new_test_rdy_o=1 (after reset), tx_flit_v_o=0, sb_vld_o=0.
REQ-030 Reset mid-operation SHALL discard buffered flits and in-flight credit state without emitting a flit in the reset cycle.

Verification
REQ-031 VC_NUM=4, VC_DEPTH=2, min_gap 0, no credit returns, 8 normal flits -> 6 sent on VCs 0,1,2,0,1,2, then stall; timeout_o rises 64 cycles after last send.
REQ-032 Return credit on VC 1 during stall -> next cycle one flit sent on VC 1.
REQ-033 Send and credit return on same VC same cycle -> counter unchanged, crd_err_o stays 0; extra return at full credit -> crd_err_o=1.
REQ-034 min_gap_i=3, buffer full, credits ample -> tx_flit_v_o pulses every 4th cycle.
REQ-035 qos_hi head with VC 3 credit 0 while VC 0 has credit -> no send until VC 3 credit returns.
REQ-036 sb_rdy_i=0 with flit ready -> no send, no credit change; rst asserted with 5 buffered -> next cycle FIFO empty, credits 2 per VC.

Source files
------------

// File: rtl/v_multi_vc_sender.sv
// Test-traffic injector: buffers flits and sends each one on a credit-managed VC.
// Sending is paced by a minimum idle gap; stalls and credit overflows raise sticky flags.
module v_multi_vc_sender #(
   parameter int FLIT_W            = 256,
   parameter int BUF_DEPTH         = 8,
   parameter int VC_NUM            = 4,
   parameter int VC_DEPTH          = 2,
   parameter int GAP_W             = 8,
   parameter int TIMEOUT_THRESHOLD = 64,
   localparam int VC_IDX_W         = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   localparam int CRD_W            = $clog2(VC_DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                new_test_vld_i,
   output logic                new_test_rdy_o,
   input  logic [FLIT_W-1:0]   new_flit_i,
   input  logic                new_qos_hi_i,
   output logic                tx_flit_v_o,
   output logic [FLIT_W-1:0]   tx_flit_o,
   output logic [VC_IDX_W-1:0] tx_flit_vc_id_o,
   input  logic                tx_lcrd_v_i,
   input  logic [VC_IDX_W-1:0] tx_lcrd_id_i,
   output logic                sb_vld_o,
   input  logic                sb_rdy_i,
   output logic [VC_IDX_W-1:0] sb_vc_id_o,
   output logic [63:0]         sb_sent_cycle_o,
   input  logic [63:0]         mcycle_i,
   input  logic [GAP_W-1:0]    min_gap_i,
   output logic                timeout_o,
   output logic                crd_err_o
);

   localparam int AW      = $clog2(BUF_DEPTH);
   localparam int NRM_NUM = (VC_NUM > 1) ? VC_NUM - 1 : 1;
   localparam int STALL_W = $clog2(TIMEOUT_THRESHOLD + 1);
   localparam logic [VC_IDX_W-1:0] HI_VC     = VC_IDX_W'(VC_NUM - 1);
   localparam logic [VC_IDX_W-1:0] NRM_LAST  = VC_IDX_W'(NRM_NUM - 1);
   localparam logic [STALL_W-1:0]  STALL_THR = STALL_W'(TIMEOUT_THRESHOLD);
   localparam logic [CRD_W-1:0]    CRD_MAX   = CRD_W'(VC_DEPTH);

   logic [FLIT_W:0]     r_mem [BUF_DEPTH];
   logic [AW:0]         r_wr_ptr;
   logic [AW:0]         r_rd_ptr;
   logic [CRD_W-1:0]    r_crd [VC_NUM];
   logic [VC_IDX_W-1:0] r_rr_ptr;
   logic [GAP_W-1:0]    r_gap;
   logic [STALL_W-1:0]  r_stall;
   logic                r_timeout;
   logic                r_crd_err;

   logic [FLIT_W:0]     w_head;
   logic                w_head_qos;
   logic                w_hi_sel;
   logic                w_empty;
   logic                w_full;
   logic                w_enq;
   logic                w_send;
   logic [VC_IDX_W-1:0] w_rr_vc;
   logic [VC_IDX_W-1:0] w_sel_vc;
   logic [VC_NUM-1:0]   w_ovf;
   logic [STALL_W-1:0]  w_stall_next;

   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_enq      = new_test_vld_i && !w_full;
   assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
   assign w_head_qos = w_head[FLIT_W];
   assign w_hi_sel   = (VC_NUM > 1) && w_head_qos;
   assign w_sel_vc   = w_hi_sel ? HI_VC : w_rr_vc;

   // Reset gates the send so nothing leaves the block in the reset cycle.
   assign w_send = !rst && !w_empty && (r_crd[w_sel_vc] != '0) && sb_rdy_i && (r_gap >= min_gap_i);

   // First normal VC with credit, scanning from the RR pointer; falls back to the pointer itself.
   always_comb begin : p_rr_pick
      logic [VC_IDX_W:0] v_sum;
      logic              v_found;
      w_rr_vc = r_rr_ptr;
      v_found = 1'b0;
      v_sum   = '0;
      for (int i = 0; i < NRM_NUM; i++) begin
         v_sum = {1'b0, r_rr_ptr} + (VC_IDX_W + 1)'(i);
         if (v_sum >= (VC_IDX_W + 1)'(NRM_NUM)) begin
            v_sum = v_sum - (VC_IDX_W + 1)'(NRM_NUM);
         end
         if (!v_found && (r_crd[v_sum[VC_IDX_W-1:0]] != '0)) begin
            v_found = 1'b1;
            w_rr_vc = v_sum[VC_IDX_W-1:0];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
         logic w_inc;
         logic w_dec;
         assign w_inc     = tx_lcrd_v_i && (tx_lcrd_id_i == VC_IDX_W'(gi));
         assign w_dec     = w_send && (w_sel_vc == VC_IDX_W'(gi));
         assign w_ovf[gi] = w_inc && !w_dec && (r_crd[gi] == CRD_MAX);

         always_ff @(posedge clk) begin
            if (rst) begin
               r_crd[gi] <= CRD_MAX;
            end else if (w_inc && !w_dec && (r_crd[gi] != CRD_MAX)) begin
               r_crd[gi] <= r_crd[gi] + CRD_W'(1);
            end else if (w_dec && !w_inc) begin
               r_crd[gi] <= r_crd[gi] - CRD_W'(1);
            end
         end
      end
   endgenerate

   assign w_stall_next = (w_send || w_empty)  ? '0 :
                         (r_stall == STALL_THR) ? r_stall : r_stall + STALL_W'(1);

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {new_qos_hi_i, new_flit_i};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_rr_ptr  <= '0;
         r_gap     <= '1;
         r_stall   <= '0;
         r_timeout <= 1'b0;
         r_crd_err <= 1'b0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
         end
         if (w_send) begin
            r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
         end
         if (w_send && !w_hi_sel) begin
            r_rr_ptr <= (w_rr_vc == NRM_LAST) ? '0 : w_rr_vc + VC_IDX_W'(1);
         end
         if (w_send) begin
            r_gap <= '0;
         end else if (!(&r_gap)) begin
            r_gap <= r_gap + GAP_W'(1);
         end
         r_stall <= w_stall_next;
         if (w_stall_next == STALL_THR) begin
            r_timeout <= 1'b1;
         end
         if (|w_ovf) begin
            r_crd_err <= 1'b1;
         end
      end
   end

   assign new_test_rdy_o  = !w_full;
   assign tx_flit_v_o     = w_send;
   assign tx_flit_o       = w_head[FLIT_W-1:0];
   assign tx_flit_vc_id_o = w_sel_vc;
   assign sb_vld_o        = w_send;
   assign sb_vc_id_o      = w_sel_vc;
   assign sb_sent_cycle_o = mcycle_i;
   assign timeout_o       = r_timeout;
   assign crd_err_o       = r_crd_err;

endmodule

// File: tb/tb_v_multi_vc_sender.sv
// Directed bench for v_multi_vc_sender: a vector table for basic sends plus
// hand-written sequences for credit, gap, qos, reset and timeout corner cases.
module tb_v_multi_vc_sender;

   localparam int FW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          new_test_vld_i = 1'b0;
   logic          new_test_rdy_o;
   logic [FW-1:0] new_flit_i = '0;
   logic          new_qos_hi_i = 1'b0;
   logic          tx_flit_v_o;
   logic [FW-1:0] tx_flit_o;
   logic [1:0]    tx_flit_vc_id_o;
   logic          tx_lcrd_v_i = 1'b0;
   logic [1:0]    tx_lcrd_id_i = '0;
   logic          sb_vld_o;
   logic          sb_rdy_i = 1'b1;
   logic [1:0]    sb_vc_id_o;
   logic [63:0]   sb_sent_cycle_o;
   logic [63:0]   mcycle_i;
   logic [7:0]    min_gap_i = '0;
   logic          timeout_o;
   logic          crd_err_o;

   logic [63:0]   cyc = 64'h0000_0001_0000_0000;
   int            n_pass = 0;
   int            n_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 64'd1;
   assign mcycle_i = cyc;

   v_multi_vc_sender #(
      .FLIT_W(FW), .BUF_DEPTH(8), .VC_NUM(4), .VC_DEPTH(2), .GAP_W(8), .TIMEOUT_THRESHOLD(64)
   ) dut (
      .clk(clk), .rst(rst),
      .new_test_vld_i(new_test_vld_i), .new_test_rdy_o(new_test_rdy_o),
      .new_flit_i(new_flit_i), .new_qos_hi_i(new_qos_hi_i),
      .tx_flit_v_o(tx_flit_v_o), .tx_flit_o(tx_flit_o), .tx_flit_vc_id_o(tx_flit_vc_id_o),
      .tx_lcrd_v_i(tx_lcrd_v_i), .tx_lcrd_id_i(tx_lcrd_id_i),
      .sb_vld_o(sb_vld_o), .sb_rdy_i(sb_rdy_i), .sb_vc_id_o(sb_vc_id_o),
      .sb_sent_cycle_o(sb_sent_cycle_o), .mcycle_i(mcycle_i), .min_gap_i(min_gap_i),
      .timeout_o(timeout_o), .crd_err_o(crd_err_o)
   );

   typedef struct packed {
      logic          vld;
      logic [FW-1:0] flit;
      logic          qos;
      logic          lv;
      logic [1:0]    lid;
      logic          sbr;
      logic          ev;
      logic [1:0]    evc;
      logic [FW-1:0] ef;
      logic          erdy;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic step_chk(input string tag, input logic ev, input logic [1:0] evc, input logic [FW-1:0] ef);
      @(negedge clk);
      $display("%s cyc=%0h tx_v=%0b vc=%0d flit=%h", tag, cyc, tx_flit_v_o, tx_flit_vc_id_o, tx_flit_o);
      chk({tag, "_txv"}, 64'(tx_flit_v_o), 64'(ev));
      chk({tag, "_sbv"}, 64'(sb_vld_o), 64'(ev));
      if (ev) begin
         chk({tag, "_vc"}, 64'(tx_flit_vc_id_o), 64'(evc));
         chk({tag, "_flit"}, 64'(tx_flit_o), 64'(ef));
         chk({tag, "_sbvc"}, 64'(sb_vc_id_o), 64'(evc));
         chk({tag, "_sbcyc"}, sb_sent_cycle_o, cyc);
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      new_test_vld_i = 1'b0;
      tx_lcrd_v_i = 1'b0;
      step_chk(tag, 1'b0, 2'd0, '0);
      next_cycle();
      rst = 1'b0;
   endtask

   initial begin
      int n_sent;
      int last_k;
      int to_k;
      logic [1:0] vcs [8];
      logic ev;

      tbl[0] = '{1'b1, 16'h1111, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b1};
      tbl[1] = '{1'b1, 16'h2222, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 16'h1111, 1'b1};
      tbl[2] = '{1'b1, 16'h3333, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 16'h2222, 1'b1};
      tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 16'h3333, 1'b1};
      tbl[4] = '{1'b1, 16'h4444, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b1};
      tbl[5] = '{1'b1, 16'h5555, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1};
      tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 2'd2, 16'h4444, 1'b1};
      tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 16'h5555, 1'b1};
      tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b1};

      // Power-on reset and reset-state outputs
      do_reset("init_rst");
      step_chk("rst_state", 1'b0, 2'd0, '0);
      chk("rst_rdy", 64'(new_test_rdy_o), 64'd1);
      chk("rst_timeout", 64'(timeout_o), 64'd0);
      chk("rst_crd_err", 64'(crd_err_o), 64'd0);
      next_cycle();

      // Table-driven basic sends
      for (int r = 0; r < 9; r++) begin
         new_test_vld_i = tbl[r].vld;
         new_flit_i     = tbl[r].flit;
         new_qos_hi_i   = tbl[r].qos;
         tx_lcrd_v_i    = tbl[r].lv;
         tx_lcrd_id_i   = tbl[r].lid;
         sb_rdy_i       = tbl[r].sbr;
         step_chk($sformatf("tbl%0d", r), tbl[r].ev, tbl[r].evc, tbl[r].ef);
         chk($sformatf("tbl%0d_rdy", r), 64'(new_test_rdy_o), 64'(tbl[r].erdy));
         chk($sformatf("tbl%0d_err", r), 64'(crd_err_o), 64'd0);
         next_cycle();
      end
      new_test_vld_i = 1'b0;
      new_qos_hi_i = 1'b0;
      tx_lcrd_v_i = 1'b0;
      sb_rdy_i = 1'b1;

      // Send and return on the same VC, then an overflowing return
      do_reset("q33_rst");
      new_test_vld_i = 1'b1;
      new_flit_i = 16'hC001;
      step_chk("q33_enq", 1'b0, 2'd0, '0);
      next_cycle();
      new_test_vld_i = 1'b0;
      tx_lcrd_v_i = 1'b1;
      tx_lcrd_id_i = 2'd0;
      step_chk("q33_same", 1'b1, 2'd0, 16'hC001);
      chk("q33_err_a", 64'(crd_err_o), 64'd0);
      next_cycle();
      step_chk("q33_extra", 1'b0, 2'd0, '0);
      chk("q33_err_b", 64'(crd_err_o), 64'd0);
      next_cycle();
      tx_lcrd_v_i = 1'b0;
      @(negedge clk);
      chk("q33_err_set", 64'(crd_err_o), 64'd1);
      next_cycle();
      @(negedge clk);
      chk("q33_err_sticky", 64'(crd_err_o), 64'd1);
      next_cycle();

      // qos head blocked on VC 3 while VC 0 has credit
      do_reset("q35_rst");
      for (int c = 0; c < 13; c++) begin
         new_test_vld_i = (c < 4);
         new_qos_hi_i   = (c < 3);
         new_flit_i     = 16'(32'hD001 + c);
         tx_lcrd_v_i    = (c == 9);
         tx_lcrd_id_i   = 2'd3;
         case (c)
            1:       step_chk($sformatf("q35_c%0d", c), 1'b1, 2'd3, 16'hD001);
            2:       step_chk($sformatf("q35_c%0d", c), 1'b1, 2'd3, 16'hD002);
            10:      step_chk($sformatf("q35_c%0d", c), 1'b1, 2'd3, 16'hD003);
            11:      step_chk($sformatf("q35_c%0d", c), 1'b1, 2'd0, 16'hD004);
            default: step_chk($sformatf("q35_c%0d", c), 1'b0, 2'd0, '0);
         endcase
         next_cycle();
      end
      new_qos_hi_i = 1'b0;
      tx_lcrd_v_i = 1'b0;

      // Fill with sb_rdy low, then paced sends with min_gap 3
      do_reset("gap_rst");
      min_gap_i = 8'd3;
      sb_rdy_i = 1'b0;
      for (int k = 0; k < 9; k++) begin
         new_test_vld_i = 1'b1;
         new_flit_i = 16'(32'hB000 + k);
         step_chk($sformatf("fill%0d", k), 1'b0, 2'd0, '0);
         chk($sformatf("fill%0d_rdy", k), 64'(new_test_rdy_o), (k < 8) ? 64'd1 : 64'd0);
         next_cycle();
      end
      new_test_vld_i = 1'b0;
      sb_rdy_i = 1'b1;
      for (int k = 0; k < 9; k++) begin
         ev = ((k % 4) == 0);
         step_chk($sformatf("gap%0d", k), ev, 2'(k / 4), 16'(32'hB000 + k / 4));
         if (k == 1) chk("gap_rdy_after_deq", 64'(new_test_rdy_o), 64'd1);
         next_cycle();
      end

      // Reset with five flits buffered and a send otherwise due
      min_gap_i = 8'd0;
      do_reset("midop_rst");

      // Eight normal flits, no returns: six sends then stall into timeout
      n_sent = 0;
      last_k = -1;
      to_k = -1;
      for (int k = 0; k < 90; k++) begin
         new_test_vld_i = (k < 8);
         new_flit_i = 16'(32'hA000 + k);
         @(negedge clk);
         if (k < 8) chk($sformatf("q31_rdy%0d", k), 64'(new_test_rdy_o), 64'd1);
         if (tx_flit_v_o) begin
            $display("q31 send k=%0d vc=%0d flit=%h", k, tx_flit_vc_id_o, tx_flit_o);
            chk($sformatf("q31_flit%0d", n_sent), 64'(tx_flit_o), 64'(32'hA000 + n_sent));
            if (n_sent < 8) vcs[n_sent] = tx_flit_vc_id_o;
            n_sent++;
            last_k = k;
         end
         if (timeout_o && (to_k < 0)) to_k = k;
         next_cycle();
      end
      new_test_vld_i = 1'b0;
      chk("q31_nsent", 64'(n_sent), 64'd6);
      for (int i = 0; i < 6; i++) chk($sformatf("q31_vc%0d", i), 64'(vcs[i]), 64'(i % 3));
      chk("q31_last_send", 64'(last_k), 64'd6);
      chk("q31_timeout_cycle", 64'(to_k), 64'(last_k + 65));

      // Credit return on VC 1 during the stall: usable one cycle later
      tx_lcrd_v_i = 1'b1;
      tx_lcrd_id_i = 2'd1;
      step_chk("q32_ret", 1'b0, 2'd0, '0);
      next_cycle();
      tx_lcrd_v_i = 1'b0;
      step_chk("q32_send", 1'b1, 2'd1, 16'hA006);
      next_cycle();
      step_chk("q32_after", 1'b0, 2'd0, '0);
      chk("q32_timeout_sticky", 64'(timeout_o), 64'd1);
      chk("q32_crd_err", 64'(crd_err_o), 64'd0);
      next_cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
